// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer blocks (write and read side).
// Gray helpers run at the widest legal pointer width; callers zero-extend and slice.
package fifo_pkg;

    localparam int FIFO_MAXW = 13;

    function automatic int unsigned depth_of(input int unsigned asz);
        return 32'd1 << asz;
    endfunction

    function automatic logic [FIFO_MAXW-1:0] bin2gray(input logic [FIFO_MAXW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // XOR-cascade from the MSB down, then mask to the requested width.
    function automatic logic [FIFO_MAXW-1:0] gray2bin(input logic [FIFO_MAXW-1:0] g,
                                                      input int unsigned w);
        logic [FIFO_MAXW-1:0] b;
        logic [FIFO_MAXW-1:0] mask;
        b[FIFO_MAXW-1] = g[FIFO_MAXW-1];
        for (int i = FIFO_MAXW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        mask = FIFO_MAXW'((64'd1 << w) - 64'd1);
        return b & mask;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter, width-parametrised.
module fifo_gray2bin
    import fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic [FIFO_MAXW-1:0] wide_s;

    // Widen, convert with the shared helper, then narrow back.
    always_comb begin
        wide_s = gray2bin(FIFO_MAXW'(gray), W);
        bin    = wide_s[W-1:0];
    end

endmodule

// File: rtl/wptr_full_prog.sv
// Write-side pointer/status block of the async FIFO: Gray write pointer, full,
// almost-full, fill level, free space, sticky overflow and high-water mark.
module wptr_full_prog
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE   = 4,
    parameter int AF_DEFAULT = (1 << ADDRSIZE) - 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   af_thresh,
    input  logic                ovf_clr,
    input  logic                hwm_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic [ADDRSIZE:0]   wfree,
    output logic                wovf,
    output logic [ADDRSIZE:0]   whwm
);

    localparam int AW1 = ADDRSIZE + 1;
    localparam logic [AW1-1:0] DEPTH_W = AW1'(depth_of(ADDRSIZE));
    localparam logic [AW1-1:0] AF_W    = AW1'(AF_DEFAULT);

    if (ADDRSIZE < 2 || ADDRSIZE > 12) begin : g_bad_addrsize
        $error("wptr_full_prog: ADDRSIZE must be in 2..12");
    end

    logic [AW1-1:0] wbin_q, wbin_d;
    logic [AW1-1:0] wptr_q, wptr_d;
    logic           wfull_q, wfull_d;
    logic           waf_q, waf_d;
    logic [AW1-1:0] wlevel_q, wlevel_d;
    logic [AW1-1:0] wfree_q, wfree_d;
    logic           wovf_q, wovf_d;
    logic [AW1-1:0] whwm_q, whwm_d;

    logic [AW1-1:0]       rbin_s;
    logic                 wen_s;
    logic [AW1-1:0]       diff_s;
    logic [AW1-1:0]       lvl_s;
    logic [AW1-1:0]       thr_s;
    logic [FIFO_MAXW-1:0] gray_wide_s;

    fifo_gray2bin #(.W(AW1)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin_s)
    );

    // Next-state computation for pointer, level and status flags.
    always_comb begin
        wen_s       = winc & ~wfull_q;
        wbin_d      = wbin_q + {{ADDRSIZE{1'b0}}, wen_s};
        gray_wide_s = bin2gray(FIFO_MAXW'(wbin_d));
        wptr_d      = gray_wide_s[AW1-1:0];

        // Level only ever overstates occupancy since the read pointer lags.
        diff_s = wbin_d - rbin_s;
        if (diff_s > DEPTH_W) begin
            lvl_s = DEPTH_W;
        end else begin
            lvl_s = diff_s;
        end

        if (af_thresh == {AW1{1'b0}}) begin
            thr_s = AF_W;
        end else if (af_thresh > DEPTH_W) begin
            thr_s = DEPTH_W;
        end else begin
            thr_s = af_thresh;
        end

        wlevel_d = lvl_s;
        wfree_d  = DEPTH_W - lvl_s;
        wfull_d  = (lvl_s == DEPTH_W);
        waf_d    = (lvl_s >= thr_s);

        // A blocked write outranks a simultaneous clear.
        if (winc & wfull_q) begin
            wovf_d = 1'b1;
        end else if (ovf_clr) begin
            wovf_d = 1'b0;
        end else begin
            wovf_d = wovf_q;
        end

        // Reload with the current level so a full FIFO keeps reporting DEPTH.
        if (hwm_clr) begin
            whwm_d = lvl_s;
        end else if (lvl_s > whwm_q) begin
            whwm_d = lvl_s;
        end else begin
            whwm_d = whwm_q;
        end
    end

    // State registers, asynchronously reset.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= {AW1{1'b0}};
            wptr_q   <= {AW1{1'b0}};
            wfull_q  <= 1'b0;
            waf_q    <= 1'b0;
            wlevel_q <= {AW1{1'b0}};
            wfree_q  <= DEPTH_W;
            wovf_q   <= 1'b0;
            whwm_q   <= {AW1{1'b0}};
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            waf_q    <= waf_d;
            wlevel_q <= wlevel_d;
            wfree_q  <= wfree_d;
            wovf_q   <= wovf_d;
            whwm_q   <= whwm_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = waf_q;
    assign wlevel       = wlevel_q;
    assign wfree        = wfree_q;
    assign wovf         = wovf_q;
    assign whwm         = whwm_q;

endmodule
